// File: rtl/matrix_row_driver.sv
// LED dot-matrix row scanner with double-buffered frame storage.
// A shadow buffer is filled through a valid/ready load port and copied to the
// active (displayed) buffer only on a frame boundary. Each driven row is
// preceded by BLANK_CYCLES cycles with every row off to suppress ghosting.
module matrix_row_driver #(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            scan_tick,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [2:0]      load_row,
  input  logic [COLS-1:0] load_data,
  input  logic            load_last,
  output logic [2:0]      row_sel,
  output logic [ROWS-1:0] row_en,
  output logic [COLS-1:0] col_data,
  output logic            frame_start
);

  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    ROW_LAST   = 3'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_ONE  = ROWS'(1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   blank_cnt_reg;
  logic            swap_pending_reg;
  logic [COLS-1:0] shadow_reg [ROWS];
  logic [COLS-1:0] active_reg [ROWS];

  logic            accept;
  logic            frame_edge;
  logic            do_swap;
  logic [COLS-1:0] active_row;

  // No new beats are taken while a completed update waits for its frame boundary.
  assign load_ready = ~swap_pending_reg;
  assign accept     = load_valid & ~swap_pending_reg;

  // A frame begins when a tick leaves IDLE or wraps the last row back to row 0.
  assign frame_edge = scan_tick &
                      ((state_reg == IDLE) ||
                       ((state_reg == DRIVE) && (row_sel == ROW_LAST)));
  assign do_swap    = frame_edge & swap_pending_reg;

  // Select the displayed pixels of the row about to be driven.
  always_comb begin
    active_row = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_sel == 3'(i)) begin
        active_row = active_reg[i];
      end
    end
  end

  // Frame buffers and the pending-swap flag; the active copy only moves on a frame edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
      swap_pending_reg <= 1'b0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (do_swap) begin
          active_reg[i] <= shadow_reg[i];
        end
        // Rows at or beyond ROWS match no entry, so such beats are dropped.
        if (accept && (load_row == 3'(i))) begin
          shadow_reg[i] <= load_data;
        end
      end
      if (do_swap) begin
        swap_pending_reg <= 1'b0;
      end else if (accept && load_last) begin
        swap_pending_reg <= 1'b1;
      end
    end
  end

  // Scan state machine with registered row strobes, column data and frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      blank_cnt_reg <= '0;
      row_sel       <= 3'd0;
      row_en        <= '0;
      col_data      <= '0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          row_en   <= '0;
          col_data <= '0;
          if (scan_tick) begin
            state_reg     <= BLANK;
            row_sel       <= 3'd0;
            blank_cnt_reg <= '0;
            frame_start   <= 1'b1;
          end
        end
        BLANK: begin
          // Ticks are ignored here; the row is only lit after the full gap.
          row_en   <= '0;
          col_data <= '0;
          if (blank_cnt_reg == BLANK_LAST) begin
            state_reg     <= DRIVE;
            blank_cnt_reg <= '0;
            row_en        <= ROW_ONE << row_sel;
            col_data      <= active_row;
          end else begin
            blank_cnt_reg <= blank_cnt_reg + 1'b1;
          end
        end
        DRIVE: begin
          if (scan_tick) begin
            state_reg     <= BLANK;
            blank_cnt_reg <= '0;
            row_en        <= '0;
            col_data      <= '0;
            if (row_sel == ROW_LAST) begin
              row_sel     <= 3'd0;
              frame_start <= 1'b1;
            end else begin
              row_sel <= row_sel + 3'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          row_en    <= '0;
          col_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_row_driver.sv
// Scoreboard bench for matrix_row_driver: the stimulus process updates a
// frame-level reference model and queues the expected row-drive and
// frame-start events; a separate monitor pops and compares them as the DUT
// presents them.
module tb_matrix_row_driver;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int BLANK = 2;

  logic            clock;
  logic            reset;
  logic            scan_tick;
  logic            load_valid;
  logic            load_ready;
  logic [2:0]      load_row;
  logic [COLS-1:0] load_data;
  logic            load_last;
  logic [2:0]      row_sel;
  logic [ROWS-1:0] row_en;
  logic [COLS-1:0] col_data;
  logic            frame_start;

  matrix_row_driver #(.ROWS(ROWS), .COLS(COLS), .BLANK_CYCLES(BLANK)) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_tick  (scan_tick),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_row   (load_row),
    .load_data  (load_data),
    .load_last  (load_last),
    .row_sel    (row_sel),
    .row_en     (row_en),
    .col_data   (col_data),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int              cyc;
    int              row;
    logic [COLS-1:0] col;
  } row_evt_t;

  row_evt_t row_q[$];
  int       frame_q[$];

  // Reference model: frame buffers, pending flag and scan position in time.
  logic [COLS-1:0] m_shadow [ROWS];
  logic [COLS-1:0] m_active [ROWS];
  bit  m_pending;
  bit  m_idle;
  int  m_row;
  int  m_drive_start;
  int  cyc;
  bit  mon_en;

  int total;
  int bad;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ROWS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending     = 1'b0;
    m_idle        = 1'b1;
    m_row         = 0;
    m_drive_start = 0;
    row_q.delete();
    frame_q.delete();
  endtask

  // One clock: drive inputs mid-cycle, then advance the model for that edge.
  task automatic step(input bit rst, input bit tk, input bit lv,
                      input logic [2:0] lr, input logic [COLS-1:0] ld, input bit ll);
    int c;
    bit acc;
    bit eff;
    bit bnd;
    row_evt_t e;
    @(negedge clock);
    reset      = rst;
    scan_tick  = tk;
    load_valid = lv;
    load_row   = lr;
    load_data  = ld;
    load_last  = ll;
    @(posedge clock);
    c   = cyc;
    cyc = cyc + 1;
    if (rst) begin
      model_clear();
    end else begin
      acc = lv && !m_pending;
      eff = tk && (m_idle || c >= m_drive_start);
      bnd = 1'b0;
      if (eff) begin
        if (m_idle || m_row == ROWS - 1) begin
          m_row = 0;
          bnd   = 1'b1;
        end else begin
          m_row = m_row + 1;
        end
        m_idle        = 1'b0;
        m_drive_start = c + 1 + BLANK;
      end
      if (bnd) begin
        frame_q.push_back(c + 1);
        if (m_pending) begin
          for (int i = 0; i < ROWS; i++) m_active[i] = m_shadow[i];
          m_pending = 1'b0;
        end
      end
      if (eff) begin
        e.cyc = c + 1 + BLANK;
        e.row = m_row;
        e.col = m_active[m_row];
        row_q.push_back(e);
      end
      if (acc) begin
        if (int'(lr) < ROWS) m_shadow[lr] = ld;
        if (ll) m_pending = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic tick_every(input int n, input int period);
    repeat (n) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
      idle(period - 1);
    end
  endtask

  task automatic load(input logic [2:0] lr, input logic [COLS-1:0] ld, input bit ll);
    step(1'b0, 1'b0, 1'b1, lr, ld, ll);
  endtask

  // Tick along (bounded) until the model says row tr is being driven.
  task automatic reach_row(input int tr, input bit need_idle_pending);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (!m_idle && m_row == tr && cyc >= m_drive_start &&
          (!need_idle_pending || !m_pending)) begin
        ok = 1'b1;
        break;
      end
      if (m_idle || cyc >= m_drive_start) step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
      else idle(1);
    end
    chk("reach_row_bound", ok, 1);
  endtask

  // Monitor: compares DUT outputs against the model and the event queues.
  initial begin
    logic [ROWS-1:0] prev_en;
    row_evt_t e;
    int f;
    bit quiet;
    prev_en = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("load_ready", load_ready, !m_pending);
        chk("row_sel", row_sel, m_row);
        chk("row_en_onehot", $countones(row_en) <= 1, 1);
        quiet = m_idle || (cyc < m_drive_start);
        if (quiet) begin
          chk("quiet_row_en", row_en, 0);
          chk("quiet_col_data", col_data, 0);
        end
        while (row_q.size() > 0 && row_q[0].cyc < cyc) begin
          e = row_q.pop_front();
          chk("row_drive_missed_at", e.cyc, -1);
        end
        if (row_en != '0 && prev_en == '0) begin
          if (row_q.size() == 0) begin
            chk("row_drive_unexpected", row_en, 0);
          end else begin
            e = row_q.pop_front();
            chk("row_drive_cycle", cyc, e.cyc);
            chk("row_en", row_en, longint'(1) << e.row);
            chk("col_data", col_data, e.col);
          end
        end
        while (frame_q.size() > 0 && frame_q[0] < cyc) begin
          f = frame_q.pop_front();
          chk("frame_start_missed_at", f, -1);
        end
        if (frame_start) begin
          if (frame_q.size() == 0) begin
            chk("frame_start_unexpected", frame_start, 0);
          end else begin
            f = frame_q.pop_front();
            chk("frame_start_cycle", cyc, f);
          end
        end
        prev_en = row_en;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    mon_en     = 1'b0;
    reset      = 1'b1;
    scan_tick  = 1'b0;
    load_valid = 1'b0;
    load_row   = 3'd0;
    load_data  = '0;
    load_last  = 1'b0;
    model_clear();

    step(1'b1, 1'b0, 1'b0, 3'd0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0, 1'b0);
    mon_en = 1'b1;

    // First frame from IDLE: tick at cycle 5, row 0 lit at cycle 8.
    idle(3);
    step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    idle(4);

    // Full frame load; old frame keeps showing until the wrap.
    load(3'd0, 5'h11, 1'b0);
    load(3'd1, 5'h0A, 1'b0);
    load(3'd2, 5'h04, 1'b0);
    load(3'd3, 5'h0A, 1'b0);
    load(3'd4, 5'h11, 1'b0);
    load(3'd5, 5'h1F, 1'b0);
    load(3'd6, 5'h00, 1'b1);
    tick_every(7, 4);
    tick_every(7, 4);

    // Minimum tick period.
    tick_every(15, 3);

    // Tick during BLANK is dropped.
    step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    idle(3);

    // load_last coincides with the frame boundary.
    load(3'd2, 5'h07, 1'b0);
    reach_row(ROWS - 1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 3'd4, 5'h15, 1'b1);
    idle(3);
    tick_every(14, 3);

    // Out-of-range row beat is accepted but leaves the shadow alone.
    load(3'd7, 5'h1E, 1'b1);
    tick_every(14, 3);

    // Reset mid-DRIVE after a partial load.
    load(3'd0, 5'h1B, 1'b0);
    load(3'd1, 5'h0C, 1'b0);
    reach_row(3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0, 1'b0);
    idle(3);
    tick_every(16, 4);

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(299) == 0),
           ($urandom_range(2) == 0),
           ($urandom_range(3) == 0),
           3'($urandom_range(7)),
           COLS'($urandom),
           ($urandom_range(4) == 0));
    end

    idle(10);
    chk("row_q_drained", row_q.size(), 0);
    chk("frame_q_drained", frame_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
